paddle_ctrl: RTL and testbench

Downstream consumer of the two-bit PMOD button breakout (raw `up`/`down` levels). It synchronises and debounces both button levels and converts them into a saturating paddle vertical position for the pong renderer and collision logic. Position updates at a fixed movement rate, so hold time maps linearly to travel.

---
 rtl/paddle_ctrl.sv | 107 ++++++++++
 tb/tb_paddle_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_ctrl.sv
// Paddle position controller: synchronises and debounces the up/down buttons,
// then steps a saturating paddle top row once per movement tick.
module paddle_ctrl #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int STEP_CYCLES     = 200000,
   parameter int STEP            = 4,
   parameter int SCREEN_H        = 480,
   parameter int PAD_H           = 80,
   parameter int PAD_Y_INIT      = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       up,
   input  logic       down,
   output logic [9:0] pad_y,
   output logic       up_db,
   output logic       down_db,
   output logic       moving
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int TK_W = $clog2(STEP_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TK_W-1:0] TK_LAST = TK_W'(STEP_CYCLES - 1);
   localparam logic [10:0]     Y_MAX   = 11'(SCREEN_H - PAD_H);
   localparam logic [10:0]     STEP_W  = 11'(STEP);

   typedef enum logic [1:0] {IDLE, UP, DOWN} dir_t;

   // Bit 0 carries the up button, bit 1 the down button.
   logic [1:0]      s1;
   logic [1:0]      s2;
   logic [1:0]      db;
   logic [DB_W-1:0] cnt [2];
   logic [TK_W-1:0] tick_cnt;
   logic            tick;
   dir_t            dir;
   logic [10:0]     sum;
   logic [9:0]      pad_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 2'b00;
         s2 <= 2'b00;
      end else begin
         s1 <= {down, up};
         s2 <= s1;
      end
   end

   // Any cycle where s2 agrees with db restarts the stability count.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            cnt[i] <= '0;
            db[i]  <= 1'b0;
         end else if (s2[i] == db[i]) begin
            cnt[i] <= '0;
         end else if (cnt[i] == DB_LAST) begin
            db[i]  <= s2[i];
            cnt[i] <= '0;
         end else begin
            cnt[i] <= cnt[i] + DB_W'(1);
         end
      end
   end

   assign up_db   = db[0];
   assign down_db = db[1];

   always_ff @(posedge clk) begin
      if (reset || tick) tick_cnt <= '0;
      else               tick_cnt <= tick_cnt + TK_W'(1);
   end

   assign tick = (tick_cnt == TK_LAST);

   // Sum is widened to 11 bits so the bottom-bound compare cannot wrap.
   always_comb begin
      dir      = IDLE;
      pad_next = pad_y;
      sum      = {1'b0, pad_y} + STEP_W;
      case ({up_db, down_db})
         2'b10:   dir = UP;
         2'b01:   dir = DOWN;
         default: dir = IDLE;
      endcase
      if (tick) begin
         case (dir)
            UP:      pad_next = ({1'b0, pad_y} < STEP_W) ? 10'd0 : pad_y - STEP_W[9:0];
            DOWN:    pad_next = (sum > Y_MAX) ? Y_MAX[9:0] : sum[9:0];
            default: pad_next = pad_y;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pad_y  <= 10'(PAD_Y_INIT);
         moving <= 1'b0;
      end else begin
         pad_y  <= pad_next;
         moving <= (pad_next != pad_y);
      end
   end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: scenario tasks plus randomized traffic, all checked
// against a run-length / tick-count reference model of the paddle.
module tb_paddle_ctrl;

   localparam int DB_C    = 4;
   localparam int ST_C    = 8;
   localparam int STEP_PX = 4;
   localparam int SH      = 480;
   localparam int PH      = 80;
   localparam int PY0     = 200;
   localparam int YMAX    = SH - PH;

   logic       clk;
   logic       reset;
   logic       up;
   logic       down;
   logic [9:0] pad_y;
   logic       up_db;
   logic       down_db;
   logic       moving;

   int n_vec;
   int n_err;

   paddle_ctrl #(
      .DEBOUNCE_CYCLES(DB_C),
      .STEP_CYCLES    (ST_C),
      .STEP           (STEP_PX),
      .SCREEN_H       (SH),
      .PAD_H          (PH),
      .PAD_Y_INIT     (PY0)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .up     (up),
      .down   (down),
      .pad_y  (pad_y),
      .up_db  (up_db),
      .down_db(down_db),
      .moving (moving)
   );

   always #5 clk = ~clk;

   // Reference model: e counts edges since reset; raw levels kept in a ring.
   int       e;
   bit       raw_u [16];
   bit       raw_d [16];
   bit [1:0] m_db;
   int       m_pad;
   bit       m_mov;

   // Synchronised level seen before edge k: raw level sampled two edges earlier.
   function automatic bit s2_at(int ch, int k);
      if (k < 3) return 1'b0;
      return (ch == 0) ? raw_u[(k - 2) & 15] : raw_d[(k - 2) & 15];
   endfunction

   always @(posedge clk) begin : model
      int       ne;
      int       np;
      bit [1:0] ndb;
      bit       run;
      if (reset) begin
         e     <= 0;
         m_db  <= 2'b00;
         m_pad <= PY0;
         m_mov <= 1'b0;
      end else begin
         ne  = e + 1;
         ndb = m_db;
         for (int ch = 0; ch < 2; ch++) begin
            run = 1'b1;
            for (int j = 0; j < DB_C; j++)
               if (s2_at(ch, ne - j) == m_db[ch]) run = 1'b0;
            if (run) ndb[ch] = ~m_db[ch];
         end
         np = m_pad;
         if (ne % ST_C == 0) begin
            if (m_db == 2'b01) begin
               np = m_pad - STEP_PX;
               if (np < 0) np = 0;
            end else if (m_db == 2'b10) begin
               np = m_pad + STEP_PX;
               if (np > YMAX) np = YMAX;
            end
         end
         raw_u[ne & 15] <= up;
         raw_d[ne & 15] <= down;
         e     <= ne;
         m_db  <= ndb;
         m_pad <= np;
         m_mov <= (np != m_pad);
      end
   end

   task automatic apply_reset(input int n, input bit u, input bit d);
      @(negedge clk);
      reset = 1'b1;
      up    = u;
      down  = d;
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      up    = 1'b1;
      down  = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if (pad_y !== 10'd200 || up_db !== 1'b0 || moving !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: got pad_y=%0d up_db=%b moving=%b, want 200 0 0", pad_y, up_db, moving);
      end
      reset = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         n_vec++;
         if (pad_y !== 10'(m_pad) || up_db !== m_db[0] || down_db !== m_db[1] || moving !== m_mov) begin
            n_err++;
            $display("FAIL reset_release cyc %0d: got %0d %b %b %b, want %0d %b %b %b",
                     c, pad_y, up_db, down_db, moving, m_pad, m_db[0], m_db[1], m_mov);
         end
         if (c == 5 || c == 6) begin
            n_vec++;
            if (up_db !== (c == 6)) begin
               n_err++;
               $display("FAIL reset_up_db_latency cyc %0d: got up_db=%b, want %b", c, up_db, (c == 6));
            end
         end
      end
   endtask

   task automatic test_debounce();
      int rise;
      apply_reset(2, 1'b0, 1'b0);
      up = 1'b1;
      repeat (3) @(negedge clk);
      up = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         n_vec++;
         if (pad_y !== 10'(m_pad) || up_db !== m_db[0] || down_db !== m_db[1] || moving !== m_mov ||
             up_db !== 1'b0 || pad_y !== 10'd200) begin
            n_err++;
            $display("FAIL debounce_glitch cyc %0d: got %0d %b %b %b, want 200 0 0 0 (model %0d %b)",
                     c, pad_y, up_db, down_db, moving, m_pad, m_db[0]);
         end
      end
      up   = 1'b1;
      rise = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         n_vec++;
         if (pad_y !== 10'(m_pad) || up_db !== m_db[0] || down_db !== m_db[1] || moving !== m_mov) begin
            n_err++;
            $display("FAIL debounce_hold cyc %0d: got %0d %b %b %b, want %0d %b %b %b",
                     c, pad_y, up_db, down_db, moving, m_pad, m_db[0], m_db[1], m_mov);
         end
         if (up_db === 1'b1 && rise == 0) rise = c;
      end
      n_vec++;
      if (rise != 6) begin
         n_err++;
         $display("FAIL debounce_latency: got rise at cycle %0d, want 6", rise);
      end
   endtask

   task automatic test_move_up();
      apply_reset(2, 1'b0, 1'b0);
      up = 1'b1;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         n_vec++;
         if (pad_y !== 10'(m_pad) || up_db !== m_db[0] || down_db !== m_db[1] || moving !== m_mov) begin
            n_err++;
            $display("FAIL move_up cyc %0d: got %0d %b %b %b, want %0d %b %b %b",
                     c, pad_y, up_db, down_db, moving, m_pad, m_db[0], m_db[1], m_mov);
         end
      end
      // Ticks on edges 8..80 all see up_db high: ten steps of 4.
      n_vec++;
      if (pad_y !== 10'd160) begin
         n_err++;
         $display("FAIL move_up_total: got pad_y=%0d, want 160", pad_y);
      end
   endtask

   task automatic test_top_sat();
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         n_vec++;
         if (pad_y !== 10'(m_pad) || up_db !== m_db[0] || down_db !== m_db[1] || moving !== m_mov) begin
            n_err++;
            $display("FAIL top_sat cyc %0d: got %0d %b %b %b, want %0d %b %b %b",
                     c, pad_y, up_db, down_db, moving, m_pad, m_db[0], m_db[1], m_mov);
         end
      end
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         n_vec++;
         if (pad_y !== 10'd0 || moving !== 1'b0 || pad_y !== 10'(m_pad) || moving !== m_mov) begin
            n_err++;
            $display("FAIL top_sat_hold cyc %0d: got pad_y=%0d moving=%b, want 0 0", c, pad_y, moving);
         end
      end
   endtask

   task automatic test_bottom_sat();
      apply_reset(2, 1'b0, 1'b0);
      down = 1'b1;
      for (int c = 1; c <= 500; c++) begin
         @(negedge clk);
         n_vec++;
         if (pad_y !== 10'(m_pad) || up_db !== m_db[0] || down_db !== m_db[1] || moving !== m_mov ||
             pad_y > 10'd400) begin
            n_err++;
            $display("FAIL bottom_sat cyc %0d: got %0d %b %b %b, want %0d %b %b %b",
                     c, pad_y, up_db, down_db, moving, m_pad, m_db[0], m_db[1], m_mov);
         end
      end
      n_vec++;
      if (pad_y !== 10'd400 || moving !== 1'b0) begin
         n_err++;
         $display("FAIL bottom_sat_final: got pad_y=%0d moving=%b, want 400 0", pad_y, moving);
      end
   endtask

   task automatic test_both();
      int edge_n;
      int fall;
      int moved;
      apply_reset(2, 1'b0, 1'b0);
      up     = 1'b1;
      down   = 1'b1;
      edge_n = 0;
      repeat (10) begin
         @(negedge clk);
         edge_n++;
      end
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         edge_n++;
         n_vec++;
         if (pad_y !== 10'd200 || moving !== 1'b0 || up_db !== 1'b1 || down_db !== 1'b1 ||
             pad_y !== 10'(m_pad) || moving !== m_mov) begin
            n_err++;
            $display("FAIL both_hold cyc %0d: got %0d %b %b %b, want 200 1 1 0", c, pad_y, up_db, down_db, moving);
         end
      end
      up    = 1'b0;
      fall  = 0;
      moved = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         edge_n++;
         n_vec++;
         if (pad_y !== 10'(m_pad) || up_db !== m_db[0] || down_db !== m_db[1] || moving !== m_mov) begin
            n_err++;
            $display("FAIL both_release cyc %0d: got %0d %b %b %b, want %0d %b %b %b",
                     c, pad_y, up_db, down_db, moving, m_pad, m_db[0], m_db[1], m_mov);
         end
         if (up_db === 1'b0 && fall == 0) fall = edge_n;
         if (pad_y === 10'd204 && moved == 0) moved = edge_n;
      end
      n_vec++;
      if (fall == 0 || moved != (fall / ST_C + 1) * ST_C) begin
         n_err++;
         $display("FAIL both_release_step: got step at edge %0d (up_db fell at %0d), want %0d",
                  moved, fall, (fall / ST_C + 1) * ST_C);
      end
   endtask

   task automatic test_random();
      int hold;
      int c;
      apply_reset(2, 1'b0, 1'b0);
      c = 0;
      while (c < 1500) begin
         up   = 1'($urandom_range(0, 1));
         down = 1'($urandom_range(0, 1));
         hold = $urandom_range(1, 30);
         if ($urandom_range(0, 39) == 0) reset = 1'b1;
         for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            reset = 1'b0;
            c++;
            n_vec++;
            if (pad_y !== 10'(m_pad) || up_db !== m_db[0] || down_db !== m_db[1] || moving !== m_mov) begin
               n_err++;
               $display("FAIL random cyc %0d: got %0d %b %b %b, want %0d %b %b %b",
                        c, pad_y, up_db, down_db, moving, m_pad, m_db[0], m_db[1], m_mov);
            end
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      clk   = 1'b0;
      reset = 1'b1;
      up    = 1'b0;
      down  = 1'b0;
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_debounce();
      test_move_up();
      test_top_sat();
      test_bottom_sat();
      test_both();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
